// File: rtl/serial_adder_pkg.sv
// Shared types and bounds for the bit-serial adder.
// Imported by the adder top level.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder.
// Two of these plus an OR make the serial full-add cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, one bit per cycle, LSB first.
// Valid/ready on both the operand and result sides.
import serial_adder_pkg::*;

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             cout_q;

    logic load;
    logic step;
    logic last;

    logic p;
    logic g0;
    logic g1;
    logic s;
    logic c_nxt;

    half_adder u_ha0 (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .sum   (p),
        .carry (g0)
    );

    half_adder u_ha1 (
        .a     (p),
        .b     (carry_q),
        .sum   (s),
        .carry (g1)
    );

    assign c_nxt = g0 | g1;
    assign last  = (cnt_q == CNT_W'(WIDTH - 1));

    // New bit enters at the MSB so the first bit lands in bit 0.
    assign sum_nxt = (sum_q >> 1)
                   | (WIDTH'(s) << (WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (load) begin
            a_q     <= op_a;
            b_q     <= op_b;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else if (step) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            sum_q   <= sum_nxt;
            cnt_q   <= cnt_q + CNT_W'(1);
            carry_q <= c_nxt;
            if (last) begin
                cout_q <= c_nxt;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
